// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU register front end: register map,
// controller state encoding and STATUS bit positions.
package gpu_pkg;

    localparam logic [7:0] ADDR_P0      = 8'h00;
    localparam logic [7:0] ADDR_CMD     = 8'h10;
    localparam logic [7:0] ADDR_STATUS  = 8'h11;
    localparam logic [7:0] ADDR_PIXDATA = 8'h12;
    localparam logic [7:0] ADDR_LEVEL   = 8'h13;

    localparam int NUM_PARAMS = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUSY      = 2'd1,
        ST_WAIT_CMD  = 2'd2,
        ST_WAIT_FIFO = 2'd3
    } state_e;

    localparam int STAT_CMD_VALID  = 0;
    localparam int STAT_GPU_BUSY   = 1;
    localparam int STAT_FIFO_FULL  = 2;
    localparam int STAT_FIFO_EMPTY = 3;

    // Parameter registers occupy the 16-byte window starting at ADDR_P0.
    function automatic logic is_param_addr(input logic [7:0] a);
        return a[7:4] == ADDR_P0[7:4];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. DEPTH must be a power of two so the pointers wrap
// naturally. A push is accepted while full if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_CNT = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Accept pop when data exists, push when space exists or is being freed.
    always_comb begin
        do_pop   = pop && (cnt_q != '0);
        do_push  = push && ((cnt_q != FULL_CNT) || do_pop);
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage write port; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (cnt_q == FULL_CNT);
    assign empty    = (cnt_q == '0);
    assign level    = cnt_q;

endmodule

// File: rtl/gpu_regs.sv
// GPU register front end: parameter bank, command handoff with stall,
// pixel-data FIFO and status readback behind an EPP-style access port.
// Build option: GPU_REGS_READBACK_EN makes P0-P15 readable.
module gpu_regs
    import gpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   ip_addr,
    input  logic [7:0]   ip_do,
    input  logic         ip_wr,
    input  logic         ip_rd,
    output logic         ip_do_rdy,
    output logic [7:0]   ip_di,
    output logic         cmd_valid,
    input  logic         cmd_ready,
    output logic [7:0]   cmd_op,
    output logic [127:0] cmd_args,
    input  logic         gpu_busy,
    output logic [7:0]   pix_data,
    output logic         pix_valid,
    input  logic         pix_ready
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    state_e         state_q, state_d;
    logic           rdy_q, rdy_d;
    logic [7:0]     di_q, di_d;
    logic [7:0]     p_q [NUM_PARAMS];
    logic [7:0]     p_d [NUM_PARAMS];
    logic           cmd_valid_q, cmd_valid_d;
    logic [7:0]     cmd_op_q, cmd_op_d;
    logic [127:0]   cmd_args_q, cmd_args_d;
    logic [7:0]     pend_q, pend_d;

    logic [127:0]   p_flat;
    logic [7:0]     status;
    logic [7:0]     rd_val;
    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]     fifo_push_data;
    logic [LW-1:0]  fifo_level;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .pop_data  (pix_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign fifo_pop  = !fifo_empty && pix_ready;
    assign pix_valid = !fifo_empty;

    // Read mux: status, level and (optionally) the parameter bank.
    always_comb begin
        for (int i = 0; i < NUM_PARAMS; i++) begin
            p_flat[i*8 +: 8] = p_q[i];
        end
        status                  = '0;
        status[STAT_CMD_VALID]  = cmd_valid_q;
        status[STAT_GPU_BUSY]   = gpu_busy;
        status[STAT_FIFO_FULL]  = fifo_full;
        status[STAT_FIFO_EMPTY] = fifo_empty;
        rd_val = '0;
        if (ip_addr == ADDR_STATUS) begin
            rd_val = status;
        end else if (ip_addr == ADDR_LEVEL) begin
            rd_val = 8'(fifo_level);
        end
`ifdef GPU_REGS_READBACK_EN
        else if (is_param_addr(ip_addr)) begin
            rd_val = p_q[ip_addr[3:0]];
        end
`endif
    end

    // Next-state logic for the access controller and everything it owns.
    // Valid/ready: a command transfers in any cycle where cmd_valid and
    // cmd_ready are both 1; cmd_op/cmd_args are frozen while cmd_valid=1.
    always_comb begin
        state_d        = state_q;
        rdy_d          = rdy_q;
        di_d           = di_q;
        p_d            = p_q;
        cmd_valid_d    = cmd_valid_q && !cmd_ready;
        cmd_op_d       = cmd_op_q;
        cmd_args_d     = cmd_args_q;
        pend_d         = pend_q;
        fifo_push      = 1'b0;
        fifo_push_data = pend_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ip_wr) begin
                    state_d = ST_BUSY;
                    rdy_d   = 1'b0;
                    if (is_param_addr(ip_addr)) begin
                        p_d[ip_addr[3:0]] = ip_do;
                    end else if (ip_addr == ADDR_CMD) begin
                        if (cmd_valid_q) begin
                            state_d = ST_WAIT_CMD;
                            pend_d  = ip_do;
                        end else begin
                            cmd_valid_d = 1'b1;
                            cmd_op_d    = ip_do;
                            cmd_args_d  = p_flat;
                        end
                    end else if (ip_addr == ADDR_PIXDATA) begin
                        if (!fifo_full) begin
                            fifo_push      = 1'b1;
                            fifo_push_data = ip_do;
                        end else begin
                            state_d = ST_WAIT_FIFO;
                            pend_d  = ip_do;
                        end
                    end
                end else if (ip_rd) begin
                    state_d = ST_BUSY;
                    rdy_d   = 1'b0;
                    di_d    = rd_val;
                end
            end
            ST_BUSY: begin
                state_d = ST_IDLE;
                rdy_d   = 1'b1;
            end
            ST_WAIT_CMD: begin
                // Reload in the handshake cycle so cmd_valid never dips.
                if (!cmd_valid_q || cmd_ready) begin
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = pend_q;
                    cmd_args_d  = p_flat;
                    state_d     = ST_IDLE;
                    rdy_d       = 1'b1;
                end
            end
            ST_WAIT_FIFO: begin
                if (!fifo_full || fifo_pop) begin
                    fifo_push = 1'b1;
                    state_d   = ST_IDLE;
                    rdy_d     = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rdy_d   = 1'b1;
            end
        endcase
    end

    // Controller FSM and its registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rdy_q       <= 1'b1;
            di_q        <= '0;
            for (int i = 0; i < NUM_PARAMS; i++) begin
                p_q[i] <= '0;
            end
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= '0;
            cmd_args_q  <= '0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            di_q        <= di_d;
            p_q         <= p_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_args_q  <= cmd_args_d;
            pend_q      <= pend_d;
        end
    end

    assign ip_do_rdy = rdy_q;
    assign ip_di     = di_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = cmd_op_q;
    assign cmd_args  = cmd_args_q;

endmodule
